regfile_scoreboard: RTL and testbench

Parametrised successor to the CPU's two-read/one-write file register. It adds a write enable, a hardwired-zero register 0, synchronous reset clearing, and a per-register pending (scoreboard) bit. The pending bits let the decode stage detect read-after-write hazards against in-flight writebacks. The block sits between decode (read ports and reservation) and writeback (write port).

---
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read / 1-write register file with hardwired-zero R0
// and a per-register pending (scoreboard) bit for RAW hazard detection.
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH registers
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   src1, src2           read addresses (combinational read)
//   alu_out1, alu_out2   read data
//   busy1, busy2         pending bit of the addressed register
//   we, dest, data_in    writeback port (clears pending)
//   rsv_en, rsv_addr     reservation port (sets pending)
//   pending_cnt          registered population count of pending bits
// Optional build macro:
//   REGFILE_BYPASS_EN    same-cycle forwarding of writeback data to the
//                        read ports (busy forced low on a match)
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] src1,
    input  logic [ADDR_WIDTH-1:0] src2,
    output logic [DATA_WIDTH-1:0] alu_out1,
    output logic [DATA_WIDTH-1:0] alu_out2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic [ADDR_WIDTH:0]   pending_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic wr_valid, rsv_valid, cnt_inc, cnt_dec;

    // Accesses to address 0 are dropped so R0 and pend[0] stay zero.
    assign wr_valid  = we && (dest != '0);
    assign rsv_valid = rsv_en && (rsv_addr != '0);

    // Pending next-state: reserve applied after write so it wins on a collision.
    always_comb begin
        pend_d = pend_q;
        if (wr_valid) begin
            pend_d[dest] = 1'b0;
        end
        if (rsv_valid) begin
            pend_d[rsv_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Counter tracks only real bit transitions, so re-reserving a pending
    // register or writing a clear one leaves it unchanged.
    always_comb begin
        cnt_inc = rsv_valid && !pend_q[rsv_addr];
        cnt_dec = wr_valid && pend_q[dest] && !(rsv_valid && (rsv_addr == dest));
        cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    // State update with synchronous clear of data, pending bits and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_valid) begin
                regs_q[dest] <= data_in;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // Read ports.
    always_comb begin
        alu_out1 = (src1 == '0) ? '0 : regs_q[src1];
        alu_out2 = (src2 == '0) ? '0 : regs_q[src2];
        busy1    = pend_q[src1];
        busy2    = pend_q[src2];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback so a hazard resolves this cycle.
        if (wr_valid && (src1 == dest)) begin
            alu_out1 = data_in;
            busy1    = 1'b0;
        end
        if (wr_valid && (src2 == dest)) begin
            alu_out2 = data_in;
            busy2    = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] src1, src2, dest, rsv_addr;
    logic [DW-1:0] alu_out1, alu_out2, data_in;
    logic          busy1, busy2, we, rsv_en;
    logic [AW:0]   pending_cnt;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src1       (src1),
        .src2       (src2),
        .alu_out1   (alu_out1),
        .alu_out2   (alu_out2),
        .busy1      (busy1),
        .busy2      (busy2),
        .we         (we),
        .dest       (dest),
        .data_in    (data_in),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we = 1'b0; dest = '0; data_in = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        src1 = 5'd0; src2 = 5'd0;
        tick();
        tick();
        src1 = 5'd3; src2 = 5'd31;
        #1;
        n_cmp++; if (alu_out1 !== 16'h0000) begin n_err++; $display("FAIL rst_alu1: got %h exp 0000", alu_out1); end
        n_cmp++; if (alu_out2 !== 16'h0000) begin n_err++; $display("FAIL rst_alu2: got %h exp 0000", alu_out2); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy1: got %b exp 0", busy1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL rst_busy2: got %b exp 0", busy2); end
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL rst_cnt: got %0d exp 0", pending_cnt); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL rst_cnt_after: got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_write_read();
        we = 1'b1; dest = 5'd4; data_in = 16'h1234;
        tick();
        idle();
        src1 = 5'd4;
        #1;
        n_cmp++; if (alu_out1 !== 16'h1234) begin n_err++; $display("FAIL wr_alu1: got %h exp 1234", alu_out1); end
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL wr_nonpend_cnt: got %0d exp 0", pending_cnt); end
        // Write and reserve to R0 are both ignored.
        we = 1'b1; dest = 5'd0; data_in = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        src2 = 5'd0;
        #1;
        n_cmp++; if (alu_out2 !== 16'h0000) begin n_err++; $display("FAIL r0_alu2: got %h exp 0000", alu_out2); end
        n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL r0_busy2: got %b exp 0", busy2); end
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL r0_cnt: got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        src1 = 5'd5;
        #1;
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sb_busy1_set: got %b exp 1", busy1); end
        n_cmp++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt_set: got %0d exp 1", pending_cnt); end
        we = 1'b1; dest = 5'd5; data_in = 16'hBEEF;
        tick();
        idle();
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_busy1_clr: got %b exp 0", busy1); end
        n_cmp++; if (alu_out1 !== 16'hBEEF) begin n_err++; $display("FAIL sb_alu1: got %h exp beef", alu_out1); end
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL sb_cnt_clr: got %0d exp 0", pending_cnt); end
    endtask

    task automatic test_simultaneous();
        // Reserve and write the same register: data lands, pending stays.
        rsv_en = 1'b1; rsv_addr = 5'd7;
        we = 1'b1; dest = 5'd7; data_in = 16'h0A0A;
        tick();
        idle();
        src1 = 5'd7;
        #1;
        n_cmp++; if (alu_out1 !== 16'h0A0A) begin n_err++; $display("FAIL sim_same_alu1: got %h exp 0a0a", alu_out1); end
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sim_same_busy1: got %b exp 1", busy1); end
        n_cmp++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL sim_same_cnt: got %0d exp 1", pending_cnt); end
        // Re-reserving a pending register leaves the count alone.
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        rsv_addr = 5'd9;
        tick();
        idle();
        #1;
        n_cmp++; if (pending_cnt !== 6'd2) begin n_err++; $display("FAIL sim_rersv_cnt: got %0d exp 2", pending_cnt); end
        // Reserve 8 while writing pending 9: net zero.
        rsv_en = 1'b1; rsv_addr = 5'd8;
        we = 1'b1; dest = 5'd9; data_in = 16'h9999;
        tick();
        idle();
        src1 = 5'd8; src2 = 5'd9;
        #1;
        n_cmp++; if (pending_cnt !== 6'd2) begin n_err++; $display("FAIL sim_diff_cnt: got %0d exp 2", pending_cnt); end
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sim_diff_busy8: got %b exp 1", busy1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL sim_diff_busy9: got %b exp 0", busy2); end
        n_cmp++; if (alu_out2 !== 16'h9999) begin n_err++; $display("FAIL sim_diff_alu9: got %h exp 9999", alu_out2); end
    endtask

    task automatic test_bypass();
        rsv_en = 1'b1; rsv_addr = 5'd10;
        tick();
        idle();
        #1;
        n_cmp++; if (pending_cnt !== 6'd3) begin n_err++; $display("FAIL byp_rsv_cnt: got %0d exp 3", pending_cnt); end
        we = 1'b1; dest = 5'd10; data_in = 16'h5555;
        src1 = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (alu_out1 !== 16'h5555) begin n_err++; $display("FAIL byp_same_alu1: got %h exp 5555", alu_out1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL byp_same_busy1: got %b exp 0", busy1); end
`else
        n_cmp++; if (alu_out1 !== 16'h0000) begin n_err++; $display("FAIL byp_same_alu1: got %h exp 0000", alu_out1); end
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL byp_same_busy1: got %b exp 1", busy1); end
`endif
        tick();
        idle();
        #1;
        n_cmp++; if (alu_out1 !== 16'h5555) begin n_err++; $display("FAIL byp_after_alu1: got %h exp 5555", alu_out1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL byp_after_busy1: got %b exp 0", busy1); end
        n_cmp++; if (pending_cnt !== 6'd2) begin n_err++; $display("FAIL byp_after_cnt: got %0d exp 2", pending_cnt); end
    endtask

    task automatic test_reset_mid();
        // Retire 7 and 8, and give R6 a value that reset must wipe.
        we = 1'b1; dest = 5'd7; data_in = 16'h7777;
        tick();
        dest = 5'd8; data_in = 16'h8888;
        tick();
        dest = 5'd6; data_in = 16'h6666;
        tick();
        idle();
        #1;
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL mid_pre_cnt: got %0d exp 0", pending_cnt); end
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd6;
        tick();
        rsv_addr = 5'd12;
        tick();
        idle();
        src1 = 5'd6;
        #1;
        n_cmp++; if (pending_cnt !== 6'd3) begin n_err++; $display("FAIL mid_rsv_cnt: got %0d exp 3", pending_cnt); end
        n_cmp++; if (alu_out1 !== 16'h6666) begin n_err++; $display("FAIL mid_pre_alu6: got %h exp 6666", alu_out1); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        src1 = 5'd3; src2 = 5'd12;
        #1;
        n_cmp++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d exp 0", pending_cnt); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy3: got %b exp 0", busy1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy12: got %b exp 0", busy2); end
        src1 = 5'd6;
        #1;
        n_cmp++; if (alu_out1 !== 16'h0000) begin n_err++; $display("FAIL mid_rst_alu6: got %h exp 0000", alu_out1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy6: got %b exp 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
